// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : bcd_pkg
// Brief   : Shared state encoding, digit constants and sizing helper for
//           the sequential binary-to-BCD converter.
// Rev     : 1.0  initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Counter must hold the value N itself, not just N-1.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : bin2bcd_seq_if
// Brief     : start/busy/done handshake plus operand and packed BCD result.
// Rev       : 1.0  initial release
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd_out
  );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module : bcd_add3
// Brief  : Double-dabble digit correction: digits of 5 or more get +3.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Inputs never exceed 9 inside a valid conversion, so the sum tops out at 4'hC.
  assign d_o = (d_i >= ADD3_THRESH) ? (d_i + 4'd3) : d_i;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential shift-and-add-3 binary-to-BCD converter, one shift
//          per clock, with a start/busy/done handshake.
// Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int            SW       = 4*DIGITS + BIN_W;
  localparam int            CW       = cnt_width(BIN_W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  generate
    if ((longint'(10) ** DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_digits_check
      $fatal(1, "bin2bcd_seq: DIGITS too small to represent 2**BIN_W-1");
    end
  endgenerate

  b2b_state_t          state_q, state_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [SW-1:0]       adj;
  logic [SW-1:0]       shifted;

  assign adj[BIN_W-1:0] = scratch_q[BIN_W-1:0];

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
        .d_i (scratch_q[BIN_W + 4*k +: 4]),
        .d_o (adj[BIN_W + 4*k +: 4])
      );
    end
  endgenerate

  assign shifted = adj << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  // DONE also serves as an accept slot so a held start yields one result
  // every BIN_W+1 cycles.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          scratch_d = {{(4*DIGITS){1'b0}}, bus.bin};
          cnt_d     = CNT_LOAD;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        cnt_d     = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bcd_d   = shifted[SW-1:BIN_W];
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          scratch_d = {{(4*DIGITS){1'b0}}, bus.bin};
          cnt_d     = CNT_LOAD;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bin2bcd_seq
// Brief  : Directed scoreboard bench for bin2bcd_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;
  import bcd_pkg::*;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  logic [11:0] sb[$];
  logic [11:0] mon_exp;
  logic        mon_ok;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at a negedge while the DUT is ready to accept; returns one negedge after the accept edge.
  task automatic issue(input int v);
    bus.start = 1'b1;
    bus.bin   = 8'(v);
    sb.push_back(ref_bcd(v));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.done === 1'b1) begin
      n_done++;
      chk("sb_nonempty_at_done", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("bcd_out", {20'd0, bus.bcd_out}, {20'd0, mon_exp});
      end
      mon_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++)
        if (bus.bcd_out[4*k +: 4] > BCD_MAX) mon_ok = 1'b0;
      chk("digit_range", {31'd0, mon_ok}, 32'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int done_at;
    int d_before;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_bcd",  {20'd0, bus.bcd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 255: busy spans SHIFT x8 plus DONE
    issue(255);
    n = 0;
    done_at = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      n++;
      if (bus.done === 1'b1) done_at = n;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, 9);
    chk("t1_done_cycle", done_at, 9);

    issue(0);
    wait_done(lat);
    chk("t2_latency", lat, 9);
    @(negedge clk);

    issue(99);  wait_done(lat); chk("t3_latency_99", lat, 9);  @(negedge clk);
    issue(100); wait_done(lat); chk("t3_latency_100", lat, 9); @(negedge clk);
    issue(9);   wait_done(lat); chk("t3_latency_9", lat, 9);   @(negedge clk);

    // start mid-conversion must be dropped
    d_before = n_done;
    issue(42);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 8'd1;
    chk("t4_hold_midconv", {20'd0, bus.bcd_out}, 32'h009);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    repeat (15) @(negedge clk);
    chk("t4_done_count", n_done - d_before, 1);
    chk("t4_result", {20'd0, bus.bcd_out}, 32'h042);

    // reset during conversion
    issue(200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy",  {31'd0, bus.busy}, 32'd0);
    chk("t5_done",  {31'd0, bus.done}, 32'd0);
    chk("t5_bcd",   {20'd0, bus.bcd_out}, 32'd0);
    rst = 1'b0;
    sb.delete();
    d_before = n_done;
    repeat (15) @(negedge clk);
    chk("t5_no_done", n_done - d_before, 0);
    issue(77);
    wait_done(lat);
    chk("t5_latency", lat, 9);
    @(negedge clk);

    // start held high, sweep every operand
    bus.bin   = 8'd0;
    bus.start = 1'b1;
    sb.push_back(ref_bcd(0));
    for (int v = 0; v < 256; v++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.done !== 1'b1 && n < 30);
      chk("t6_spacing", n, 9);
      if (v < 255) begin
        bus.bin = 8'(v + 1);
        sb.push_back(ref_bcd(v + 1));
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("final_idle", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
